flag_unit: RTL
==============

FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits, legal range 4..32.
REQ-002 Parameter DEPTH, default 4: flag-stack entries, legal range 1..16.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 clk  in  1: sole clock; all state updates on its rising edge.
REQ-005 reset_n  in  1: synchronous, active-low reset.
REQ-006 op_valid  in  1: op, a_in, b_in and mask are valid this cycle; the op is accepted this cycle.
REQ-007 op  in  3: operation code. 000 NOP, 001 CMP, 010 SET, 011 CLR, 100 TOG, 101 PUSH, 110 POP, 111 LOAD.
REQ-008 a_in  in  WIDTH: CMP operand A.
REQ-009 b_in  in  WIDTH: CMP operand B.
REQ-010 mask  in  4: flag mask/value, ordered {Z,N,C,V} (bit3 = Z, bit0 = V).
REQ-011 err_clr  in  1: clears the sticky error bits.
REQ-012 flags_out  out  4: registered flag register {Z,N,C,V}.
REQ-013 done  out  1: one-cycle pulse, the cycle after an accepted op (NOP included).
REQ-014 stack_cnt  out  $clog2(DEPTH+1): number of occupied stack entries.
REQ-015 err_ovf  out  1: sticky, set by a PUSH while the stack is full.
REQ-016 err_unf  out  1: sticky, set by a POP while the stack is empty.

Function
REQ-017 The block SHALL always accept ops; there is no back-pressure, and op_valid=0 cycles change only done (forced 0) and the errors (via err_clr).
REQ-018 Latency SHALL be 1 cycle: an op accepted at edge n updates flags_out, stack_cnt and the errors at edge n, with done=1 during cycle n+1.
REQ-019 CMP SHALL compute the WIDTH+1-bit difference d = A - B and set all four flags, ignoring mask:
- Z = (A == B)
- N = d[WIDTH-1]
- C = d[WIDTH], i.e. borrow: 1 when A < B unsigned
- V = (A[msb] != B[msb]) && (d[WIDTH-1] != A[msb])
REQ-020 SET SHALL perform flags |= mask.
REQ-021 CLR SHALL perform flags &= ~mask.
REQ-022 TOG SHALL perform flags ^= mask.
REQ-023 LOAD SHALL perform flags = mask.
REQ-024 NOP SHALL leave the flags unchanged.
REQ-025 PUSH with stack_cnt < DEPTH SHALL write flags_out into entry stack_cnt, increment stack_cnt, and leave flags unchanged.
REQ-026 PUSH with stack_cnt == DEPTH SHALL leave the stack and flags unchanged and set err_ovf.
REQ-027 POP with stack_cnt > 0 SHALL load flags from entry stack_cnt-1 and decrement stack_cnt.
REQ-028 POP with stack_cnt == 0 SHALL leave flags and stack_cnt unchanged and set err_unf.
REQ-029 The stack SHALL be LIFO; there is no wrap-around, and stack_cnt saturates at 0 and DEPTH.
REQ-030 err_clr alone SHALL clear both errors at the next edge.
REQ-031 If err_clr and a new error occur in the same cycle, the error bit SHALL end set and the other bit SHALL end clear.
REQ-032 Erroring ops SHALL still produce done.
REQ-033 Undriven WIDTH bits SHALL not exist; all arithmetic SHALL be unsigned with the explicit WIDTH+1 extension.

Reset
REQ-034 With reset_n=0 at an edge, the block SHALL set flags_out=0000, stack_cnt=0, done=0, err_ovf=0 and err_unf=0.
REQ-035 Stack entry contents SHALL be don't-care after reset.
REQ-036 An op presented with reset_n=0 SHALL be discarded: no state change and no done in the following cycle.
REQ-037 Reset SHALL take priority over op_valid and err_clr.
REQ-038 The first op SHALL be accepted at the first edge with reset_n=1.

Verification
REQ-039 CMP, WIDTH=16, A=0x0005, B=0x0005 -> flags_out=1000 and done=1 the next cycle. A=0x0003, B=0x0005 -> flags_out=0110.
REQ-040 CMP A=0x7FFF, B=0xFFFF -> d=0x8000 with borrow, flags_out=0111 (N, C, V). CMP A=0x8000, B=0x0001 -> flags_out=0001.
REQ-041 LOAD 1010, SET 0101, CLR 1000, TOG 0011 on back-to-back cycles -> flags_out 1010, 1111, 0111, 0100 in successive cycles; done high 4 consecutive cycles.
REQ-042 DEPTH=4: LOAD k then PUSH, for k=1..4, then a 5th PUSH -> stack_cnt=4 and err_ovf=1. Then 4 POPs -> flags 0100, 0011, 0010, 0001. A 5th POP -> err_unf=1 and flags stay 0001.
REQ-043 With err_ovf=1, drive err_clr=1 and PUSH on a full stack in the same cycle -> err_ovf stays 1. err_clr alone the next cycle -> err_ovf=0.
REQ-044 Drive reset_n=0 in the same cycle as an accepted PUSH at stack_cnt=2 -> next cycle stack_cnt=0, flags_out=0000, done=0.

Source files
------------

// File: rtl/flag_unit_if.sv
// flag_unit_if -- operation/status bundle for flag_unit.
//
// Handshake: there is no ready. Whenever op_valid is high at a rising clk
// edge (and reset_n is high) the op is accepted at that edge; done is high
// for exactly the following cycle. err_clr is independent of op_valid.
//
// Signals:
//   op_valid  op/a_in/b_in/mask valid, accepted this cycle
//   op        3-bit operation code
//   a_in      CMP operand A (WIDTH)
//   b_in      CMP operand B (WIDTH)
//   mask      flag mask/value {Z,N,C,V}
//   err_clr   clears sticky error bits
//   flags_out registered flags {Z,N,C,V}
//   done      one-cycle pulse after an accepted op
//   stack_cnt occupied stack entries
//   err_ovf   sticky push-on-full error
//   err_unf   sticky pop-on-empty error
interface flag_unit_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [3:0]       mask;
    logic             err_clr;
    logic [3:0]       flags_out;
    logic             done;
    logic [CW-1:0]    stack_cnt;
    logic             err_ovf;
    logic             err_unf;

    modport master (
        output op_valid, op, a_in, b_in, mask, err_clr,
        input  flags_out, done, stack_cnt, err_ovf, err_unf
    );

    modport slave (
        input  op_valid, op, a_in, b_in, mask, err_clr,
        output flags_out, done, stack_cnt, err_ovf, err_unf
    );
endinterface

// File: rtl/flag_unit.sv
// flag_unit -- 4-bit condition-flag register {Z,N,C,V} with compare,
// bitwise set/clear/toggle/load and a small LIFO flag stack.
//
// Ports:
//   clk      sole clock, rising edge
//   reset_n  synchronous active-low reset (priority over everything)
//   bus      flag_unit_if.slave: op inputs, flags/status outputs
//
// Every op completes in one cycle; there is no back-pressure and no FSM.
module flag_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    flag_unit_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    // Address width for the stack storage; at least one bit so DEPTH=1 works.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_CMP  = 3'b001;
    localparam logic [2:0] OP_SET  = 3'b010;
    localparam logic [2:0] OP_CLR  = 3'b011;
    localparam logic [2:0] OP_TOG  = 3'b100;
    localparam logic [2:0] OP_PUSH = 3'b101;
    localparam logic [2:0] OP_POP  = 3'b110;
    localparam logic [2:0] OP_LOAD = 3'b111;

    logic [3:0]    flags_q;
    logic [CW-1:0] cnt_q;
    logic          done_q;
    logic          ovf_q;
    logic          unf_q;
    logic [3:0]    stack_mem [0:(1<<AW)-1];

    logic [3:0]    flags_d;
    logic [CW-1:0] cnt_d;
    logic          ovf_set;
    logic          unf_set;
    logic          push_wr;
    logic [AW-1:0] push_addr;
    logic [AW-1:0] pop_addr;
    logic [CW-1:0] cnt_m1;

    // Compare datapath: explicit WIDTH+1 extension so d[WIDTH] is the borrow.
    logic [WIDTH:0] diff;
    logic [3:0]     cmp_flags;
    logic           stack_full;
    logic           stack_empty;

    assign diff       = {1'b0, bus.a_in} - {1'b0, bus.b_in};
    assign cmp_flags  = {
        (bus.a_in == bus.b_in),
        diff[WIDTH-1],
        diff[WIDTH],
        (bus.a_in[WIDTH-1] != bus.b_in[WIDTH-1]) && (diff[WIDTH-1] != bus.a_in[WIDTH-1])
    };
    assign stack_full  = (cnt_q == DEPTH_C);
    assign stack_empty = (cnt_q == '0);
    assign cnt_m1      = cnt_q - ONE_C;
    // cnt_q < DEPTH on a legal push and cnt_q > 0 on a legal pop, so both
    // addresses fit in AW bits.
    assign push_addr   = cnt_q[AW-1:0];
    assign pop_addr    = cnt_m1[AW-1:0];

    always_comb begin
        flags_d = flags_q;
        cnt_d   = cnt_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        push_wr = 1'b0;
        if (bus.op_valid) begin
            unique case (bus.op)
                OP_NOP:  flags_d = flags_q;
                OP_CMP:  flags_d = cmp_flags;
                OP_SET:  flags_d = flags_q | bus.mask;
                OP_CLR:  flags_d = flags_q & ~bus.mask;
                OP_TOG:  flags_d = flags_q ^ bus.mask;
                OP_LOAD: flags_d = bus.mask;
                OP_PUSH: begin
                    if (stack_full) begin
                        ovf_set = 1'b1;
                    end else begin
                        push_wr = 1'b1;
                        cnt_d   = cnt_q + ONE_C;
                    end
                end
                OP_POP: begin
                    if (stack_empty) begin
                        unf_set = 1'b1;
                    end else begin
                        flags_d = stack_mem[pop_addr];
                        cnt_d   = cnt_m1;
                    end
                end
                default: flags_d = flags_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_q <= 4'b0000;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            done_q  <= bus.op_valid;
            // A new error in the same cycle as err_clr wins over the clear.
            ovf_q   <= (ovf_q & ~bus.err_clr) | ovf_set;
            unf_q   <= (unf_q & ~bus.err_clr) | unf_set;
        end
    end

    // Stack storage has no reset; contents are meaningless until pushed.
    always_ff @(posedge clk) begin
        if (reset_n && push_wr) begin
            stack_mem[push_addr] <= flags_q;
        end
    end

    assign bus.flags_out = flags_q;
    assign bus.stack_cnt = cnt_q;
    assign bus.done      = done_q;
    assign bus.err_ovf   = ovf_q;
    assign bus.err_unf   = unf_q;
endmodule
